fetch_unit: RTL

Two-stage instruction fetch front end (IF1, IF2) for the BRAM-based pipeline. It holds the PC, addresses the synchronous instruction BRAM and delivers instructions to ID. It is the consumer side of the hazard unit's control interface: it obeys pc_set/pc_set_target and the pc, IF1/IF2 and IF2/ID stall and flush strobes. A hold buffer keeps the IF2 instruction correct across stalls, because the BRAM re-reads on every clock.

---
 rtl/fetch_unit_if.sv | 48 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: hazard-unit controls, instruction BRAM port and ID-side outputs.
interface fetch_unit_if;
  logic        pc_set;
  logic [31:0] pc_set_target;
  logic        pc_stall;
  logic        IF1_IF2_stall;
  logic        IF1_IF2_flush;
  logic        IF2_ID_stall;
  logic        IF2_ID_flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if1;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic        valid_id;

  modport master (
    input  pc_set,
    input  pc_set_target,
    input  pc_stall,
    input  IF1_IF2_stall,
    input  IF1_IF2_flush,
    input  IF2_ID_stall,
    input  IF2_ID_flush,
    input  imem_rdata,
    output imem_addr,
    output pc_if1,
    output inst_id,
    output pc_id,
    output valid_id
  );

  modport slave (
    output pc_set,
    output pc_set_target,
    output pc_stall,
    output IF1_IF2_stall,
    output IF1_IF2_flush,
    output IF2_ID_stall,
    output IF2_ID_flush,
    output imem_rdata,
    input  imem_addr,
    input  pc_if1,
    input  inst_id,
    input  pc_id,
    input  valid_id
  );
endinterface

// File: rtl/fetch_unit.sv
// Two-stage (IF1/IF2) instruction fetch front end over a synchronous BRAM,
// with a hold buffer that preserves the IF2 instruction across stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_if2;
  logic        valid_if2;
  logic [31:0] hold_inst;
  logic        hold_valid;
  logic [31:0] inst_q;
  logic [31:0] pc_id_q;
  logic        valid_q;
  logic [31:0] inst_if2;

  assign bus.imem_addr = pc_q;
  assign bus.pc_if1    = pc_q;
  assign bus.inst_id   = inst_q;
  assign bus.pc_id     = pc_id_q;
  assign bus.valid_id  = valid_q;

  assign inst_if2 = hold_valid ? hold_inst
                               : bus.imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (bus.pc_set) begin
      pc_q <= {bus.pc_set_target[31:2], 2'b00};
    end else if (!bus.pc_stall) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_if2    <= 32'h0;
      valid_if2 <= 1'b0;
    end else if (bus.IF1_IF2_flush) begin
      valid_if2 <= 1'b0;
    end else if (!bus.IF1_IF2_stall) begin
      pc_if2    <= pc_q;
      valid_if2 <= 1'b1;
    end
  end

  // The BRAM re-reads every edge, so the first stalled edge snapshots
  // the data before the latched address moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_inst  <= 32'h0;
      hold_valid <= 1'b0;
    end else if (bus.IF1_IF2_flush || !bus.IF1_IF2_stall) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_inst  <= bus.imem_rdata;
      hold_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc_id_q <= 32'h0;
      valid_q <= 1'b0;
    end else if (bus.IF2_ID_flush) begin
      inst_q  <= NOP_INST;
      pc_id_q <= 32'h0;
      valid_q <= 1'b0;
    end else if (!bus.IF2_ID_stall) begin
      inst_q  <= valid_if2 ? inst_if2 : NOP_INST;
      pc_id_q <= pc_if2;
      valid_q <= valid_if2;
    end
  end

endmodule
